ddr3_wb_multiport: RTL and testbench
====================================

Name: ddr3_wb_multiport

Overview:
- N-port Wishbone front-end that shares one ddr3_top user Wishbone port among NPORTS independent masters (e.g. CPU, DMA, video).
- Arbitrates requests round-robin with a per-grant burst cap.
- Records the issuing port of every accepted request in an in-order tag FIFO, and routes each controller ack and its read data back to that port.
- Sits directly between the masters and the controller's i_wb_*/o_wb_* interface, in the controller clock domain.

Parameters:
- NPORTS, 4: number of upstream masters (2..8).
- ADDR_BITS, 24: width of the burst address; matches controller wb_addr_bits.
- DATA_BITS, 512: Wishbone data width; matches controller wb_data_bits.
- SEL_BITS, DATA_BITS/8: byte-select width.
- MAX_OUTSTANDING, 16: tag FIFO depth; power of 2, at least 2.
- BURST_MAX, 8: maximum consecutive accepted requests per grant before forced re-arbitration.
- AUX_WIDTH, 16: width of o_wb_aux; must be at least $clog2(NPORTS).

Ports:
- i_controller_clk  in  1  sole clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_p_cyc  in  NPORTS  per-port cycle.
- i_p_stb  in  NPORTS  per-port strobe.
- i_p_we  in  NPORTS  per-port write enable.
- i_p_addr  in  NPORTS*ADDR_BITS  flattened; port k occupies slice k.
- i_p_data  in  NPORTS*DATA_BITS  flattened write data.
- i_p_sel  in  NPORTS*SEL_BITS  flattened byte selects.
- o_p_stall  out  NPORTS  per-port stall.
- o_p_ack  out  NPORTS  per-port ack.
- o_p_data  out  DATA_BITS  read data, broadcast to all ports; valid with o_p_ack.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  to controller.
- o_wb_addr  out  ADDR_BITS  to controller.
- o_wb_data  out  DATA_BITS  to controller.
- o_wb_sel  out  SEL_BITS  to controller.
- o_wb_aux  out  AUX_WIDTH  zero-extended granted port index.
- i_wb_stall, i_wb_ack  in  1 each  from controller.
- i_wb_data  in  DATA_BITS  from controller.
- o_err_ack  out  1  sticky flag: ack received while tag FIFO empty.
- o_busy  out  1  high when a grant is valid or the FIFO is non-empty.

Behaviour:
- Reset (async on i_rst high):
  - gnt_vld=0, last_winner=NPORTS-1, FIFO empty, burst count=0, o_err_ack=0.
  - All o_p_stall=1, o_p_ack=0, o_wb_stb=0, o_wb_cyc=0.
  - Reset mid-operation discards all tags; later acks from the controller raise o_err_ack.
- Arbitration:
  - Evaluated only when gnt_vld=0.
  - Candidates are ports with cyc&stb. The winner is the first candidate after last_winner, cyclically.
  - The grant registers on the next edge: 1-cycle request-to-grant latency.
- Grant release:
  - Release occurs on a cycle where the granted port has stb=0 or cyc=0, or when the burst count reaches BURST_MAX after an accept.
  - On release: gnt_vld clears, last_winner takes the granted index, and the burst count clears.
  - Re-arbitration happens the following cycle.
- Forwarding (combinational mux of the granted port):
  - o_wb_stb = gnt_vld & p_stb[g] & p_cyc[g] & ~fifo_full.
  - we, addr, data and sel are muxed from port g.
  - o_wb_aux = g.
- Stall:
  - o_p_stall[g] = i_wb_stall | fifo_full | ~gnt_vld.
  - Every non-granted port has o_p_stall=1.
- Accept and push:
  - Accept = o_wb_stb & ~i_wb_stall. On accept, push g into the FIFO and increment the burst count.
- Downstream cycle:
  - o_wb_cyc = o_wb_stb | ~fifo_empty.
- Ack routing and pop:
  - On i_wb_ack with the FIFO non-empty: pop the head h.
  - o_p_ack[h] = i_p_cyc[h], in the same cycle (combinational).
  - o_p_data = i_wb_data.
  - If port h has dropped cyc, the ack is consumed silently: popped, not forwarded.
- Ack with empty FIFO: ignored; o_err_ack sets and holds until reset.
- FIFO:
  - Pointers are $clog2(MAX_OUTSTANDING)+1 bits wide and wrap modulo 2*depth.
  - full = MSBs differ and lower bits equal; empty = pointers equal.
  - Simultaneous push and pop is legal and leaves occupancy unchanged.
  - When full, push is blocked even if a pop occurs in the same cycle; stall follows fifo_full.
- Ordering: acks return in request order across all ports, because the controller is in-order.

Test Plan:
- Single port 0 issues 3 writes (addr 0x10, 0x11, 0x12), controller stall=0, ack 4 cycles later → 3 accepts; o_p_ack[0] pulses 3 times; o_p_ack[3:1]=0; o_err_ack=0.
- Ports 0, 1 and 2 all hold stb continuously with BURST_MAX=2 → grant order 0,1,2,0,…; each grant accepts exactly 2 requests; acks reach the matching port in order.
- i_wb_stall held high → no push; grant stays; burst count stays 0; all o_p_stall=1. On release of stall, the request is accepted in that cycle.
- 16 accepts with acks withheld → fifo_full; o_wb_stb=0; stall=1. A single ack then frees one slot, and the next accept occurs the cycle after.
- Port 1 drops cyc with 2 acks outstanding → both acks popped, o_p_ack[1] stays 0, and the next tag routes normally to port 2.
- Ack pulse after reset with no request → o_err_ack=1 and held; i_rst mid-burst returns all outputs to reset values.

Source files
------------

// File: rtl/ddr3_wb_multiport.sv
// N-port Wishbone front-end that shares one ddr3_top user port between several masters.
// Round-robin grant with a burst cap, plus an in-order tag FIFO that routes acks back.
module ddr3_wb_multiport #(
  parameter int unsigned NPORTS          = 4,
  parameter int unsigned ADDR_BITS       = 24,
  parameter int unsigned DATA_BITS       = 512,
  parameter int unsigned SEL_BITS        = DATA_BITS / 8,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned BURST_MAX       = 8,
  parameter int unsigned AUX_WIDTH       = 16
) (
  input  logic                          i_controller_clk,
  input  logic                          i_rst,
  input  logic [NPORTS-1:0]             i_p_cyc,
  input  logic [NPORTS-1:0]             i_p_stb,
  input  logic [NPORTS-1:0]             i_p_we,
  input  logic [NPORTS*ADDR_BITS-1:0]   i_p_addr,
  input  logic [NPORTS*DATA_BITS-1:0]   i_p_data,
  input  logic [NPORTS*SEL_BITS-1:0]    i_p_sel,
  output logic [NPORTS-1:0]             o_p_stall,
  output logic [NPORTS-1:0]             o_p_ack,
  output logic [DATA_BITS-1:0]          o_p_data,
  output logic                          o_wb_cyc,
  output logic                          o_wb_stb,
  output logic                          o_wb_we,
  output logic [ADDR_BITS-1:0]          o_wb_addr,
  output logic [DATA_BITS-1:0]          o_wb_data,
  output logic [SEL_BITS-1:0]           o_wb_sel,
  output logic [AUX_WIDTH-1:0]          o_wb_aux,
  input  logic                          i_wb_stall,
  input  logic                          i_wb_ack,
  input  logic [DATA_BITS-1:0]          i_wb_data,
  output logic                          o_err_ack,
  output logic                          o_busy
);

  localparam int unsigned IdxW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned AW   = $clog2(MAX_OUTSTANDING);
  localparam int unsigned PtrW = AW + 1;
  localparam int unsigned CntW = $clog2(BURST_MAX + 1);

  logic            gnt_vld_q, gnt_vld_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] burst_q, burst_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic            err_q;
  logic [IdxW-1:0] tag_mem [MAX_OUTSTANDING];

  logic [NPORTS-1:0] req;
  logic              win_vld;
  logic [IdxW-1:0]   win_idx;
  int unsigned       cand;
  logic              fifo_full, fifo_empty;
  logic              g_stb, g_cyc;
  logic              accept, pop, release_gnt;
  logic [IdxW-1:0]   head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = tag_mem[rd_ptr_q[AW-1:0]];

  assign req   = i_p_cyc & i_p_stb;
  assign g_stb = i_p_stb[gnt_idx_q];
  assign g_cyc = i_p_cyc[gnt_idx_q];

  // First requester after the previous winner, scanning cyclically.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      cand = (int'(last_q) + i) % NPORTS;
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = IdxW'(cand);
      end
    end
  end

  assign o_wb_stb  = gnt_vld_q & g_stb & g_cyc & ~fifo_full;
  assign o_wb_we   = i_p_we[gnt_idx_q];
  assign o_wb_addr = i_p_addr[gnt_idx_q*ADDR_BITS +: ADDR_BITS];
  assign o_wb_data = i_p_data[gnt_idx_q*DATA_BITS +: DATA_BITS];
  assign o_wb_sel  = i_p_sel[gnt_idx_q*SEL_BITS +: SEL_BITS];
  assign o_wb_aux  = AUX_WIDTH'(gnt_idx_q);
  assign o_wb_cyc  = o_wb_stb | ~fifo_empty;
  assign o_p_data  = i_wb_data;
  assign o_busy    = gnt_vld_q | ~fifo_empty;
  assign o_err_ack = err_q;

  assign accept = o_wb_stb & ~i_wb_stall;
  assign pop    = i_wb_ack & ~fifo_empty;

  always_comb begin
    o_p_stall            = '1;
    o_p_stall[gnt_idx_q] = i_wb_stall | fifo_full | ~gnt_vld_q;
  end

  // A port that dropped cyc still pops its tag, but sees no ack.
  always_comb begin
    o_p_ack = '0;
    if (pop) o_p_ack[head] = i_p_cyc[head];
  end

  always_comb begin
    gnt_vld_d   = gnt_vld_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    burst_d     = burst_q;
    release_gnt = 1'b0;
    if (!gnt_vld_q) begin
      if (win_vld) begin
        gnt_vld_d = 1'b1;
        gnt_idx_d = win_idx;
      end
    end else begin
      release_gnt = !g_stb || !g_cyc ||
                    (accept && (burst_q == CntW'(BURST_MAX - 1)));
      if (accept) burst_d = burst_q + CntW'(1);
      if (release_gnt) begin
        gnt_vld_d = 1'b0;
        last_d    = gnt_idx_q;
        burst_d   = '0;
      end
    end
  end

  always_ff @(posedge i_controller_clk or posedge i_rst) begin
    if (i_rst) begin
      gnt_vld_q <= 1'b0;
      gnt_idx_q <= '0;
      last_q    <= IdxW'(NPORTS - 1);
      burst_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      gnt_vld_q <= gnt_vld_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      if (accept) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (i_wb_ack && fifo_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge i_controller_clk) begin
    if (accept) tag_mem[wr_ptr_q[AW-1:0]] <= gnt_idx_q;
  end

endmodule

// File: tb/tb_ddr3_wb_multiport.sv
// Directed bench for ddr3_wb_multiport: 4 ports, 32-bit data, BURST_MAX=2, 16-deep tag FIFO.
module tb_ddr3_wb_multiport;

  localparam int NP = 4;
  localparam int AB = 24;
  localparam int DB = 32;
  localparam int SB = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    p_cyc, p_stb, p_we;
  logic [NP*AB-1:0] p_addr;
  logic [NP*DB-1:0] p_data;
  logic [NP*SB-1:0] p_sel;
  logic [NP-1:0]    p_stall, p_ack;
  logic [DB-1:0]    p_rdata;
  logic             wb_cyc, wb_stb, wb_we;
  logic [AB-1:0]    wb_addr;
  logic [DB-1:0]    wb_wdata;
  logic [SB-1:0]    wb_sel;
  logic [15:0]      wb_aux;
  logic             wb_stall, wb_ack;
  logic [DB-1:0]    wb_rdata;
  logic             err_ack, busy;

  int errors = 0;
  int checks = 0;

  ddr3_wb_multiport #(
    .NPORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .SEL_BITS(SB),
    .MAX_OUTSTANDING(16), .BURST_MAX(2), .AUX_WIDTH(16)
  ) dut (
    .i_controller_clk(clk), .i_rst(rst),
    .i_p_cyc(p_cyc), .i_p_stb(p_stb), .i_p_we(p_we),
    .i_p_addr(p_addr), .i_p_data(p_data), .i_p_sel(p_sel),
    .o_p_stall(p_stall), .o_p_ack(p_ack), .o_p_data(p_rdata),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_addr(wb_addr), .o_wb_data(wb_wdata), .o_wb_sel(wb_sel), .o_wb_aux(wb_aux),
    .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata),
    .o_err_ack(err_ack), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic cyc, input logic stb, input logic we,
                          input logic [AB-1:0] addr);
    p_cyc[k]           = cyc;
    p_stb[k]           = stb;
    p_we[k]            = we;
    p_addr[k*AB +: AB] = addr;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_stall"}, 64'(p_stall), 64'hF);
    chk({tag, "_ack"},   64'(p_ack),   64'h0);
    chk({tag, "_stb"},   64'(wb_stb),  64'h0);
    chk({tag, "_cyc"},   64'(wb_cyc),  64'h0);
    chk({tag, "_err"},   64'(err_ack), 64'h0);
    chk({tag, "_busy"},  64'(busy),    64'h0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_reset(tag);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; p_cyc = '0; p_stb = '0; p_we = '0; p_addr = '0; p_data = '0; p_sel = '0;
    wb_stall = 1'b0; wb_ack = 1'b0; wb_rdata = '0;
    #2;
    do_reset("rst0");

    // Port 0: three writes, acks returned afterwards
    set_port(0, 1, 1, 1, 24'h10);
    p_data[0 +: DB] = 32'hD0; p_sel[0 +: SB] = 4'hF;
    #1 chk("b_pre_stall", 64'(p_stall), 64'hF);
    tick();
    #1 chk("b_stb0", 64'(wb_stb), 64'h1);
    chk("b_addr0", 64'(wb_addr), 64'h10);
    chk("b_stall0", 64'(p_stall), 64'hE);
    chk("b_aux0", 64'(wb_aux), 64'h0);
    chk("b_we0", 64'(wb_we), 64'h1);
    chk("b_data0", 64'(wb_wdata), 64'hD0);
    chk("b_sel0", 64'(wb_sel), 64'hF);
    tick();
    p_addr[0 +: AB] = 24'h11;
    #1 chk("b_addr1", 64'(wb_addr), 64'h11);
    chk("b_stb1", 64'(wb_stb), 64'h1);
    tick();
    p_addr[0 +: AB] = 24'h12;
    #1 chk("b_cap_stb", 64'(wb_stb), 64'h0);
    chk("b_cap_stall", 64'(p_stall), 64'hF);
    chk("b_cap_cyc", 64'(wb_cyc), 64'h1);
    tick();
    #1 chk("b_addr2", 64'(wb_addr), 64'h12);
    chk("b_stb2", 64'(wb_stb), 64'h1);
    tick();
    p_stb[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb_ack = 1'b1; wb_rdata = 32'hA0 + 32'(k);
      #1 chk("b_ack", 64'(p_ack), 64'h1);
      chk("b_rdata", 64'(p_rdata), 64'(32'hA0 + 32'(k)));
      chk("b_busy", 64'(busy), 64'h1);
      tick();
    end
    wb_ack = 1'b0;
    #1 chk("b_ack_done", 64'(p_ack), 64'h0);
    chk("b_idle_busy", 64'(busy), 64'h0);
    chk("b_idle_cyc", 64'(wb_cyc), 64'h0);
    chk("b_err", 64'(err_ack), 64'h0);
    p_cyc[0] = 1'b0;

    // Ports 0,1,2 contend: round-robin, two accepts per grant
    do_reset("rst1");
    for (int k = 0; k < 3; k++) set_port(k, 1, 1, 0, 24'(32'h100 * (k + 1)));
    tick();
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 2; a++) begin
        #1 chk("c_stb", 64'(wb_stb), 64'h1);
        chk("c_aux", 64'(wb_aux), 64'(r % 3));
        chk("c_addr", 64'(wb_addr), 64'(32'h100 * (r % 3 + 1)));
        tick();
      end
      if (r == 5) p_stb = '0;
      #1 chk("c_gap", 64'(wb_stb), 64'h0);
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      wb_ack = 1'b1; wb_rdata = 32'(k);
      #1 chk("c_ack", 64'(p_ack), 64'(1 << ((k / 2) % 3)));
      chk("c_rdata", 64'(p_rdata), 64'(k));
      tick();
    end
    wb_ack = 1'b0;
    p_cyc = '0;

    // Controller stall: grant held, nothing pushed, burst count untouched
    wb_stall = 1'b1;
    set_port(3, 1, 1, 0, 24'h333);
    tick();
    for (int k = 0; k < 3; k++) begin
      #1 chk("d_stb", 64'(wb_stb), 64'h1);
      chk("d_stall", 64'(p_stall), 64'hF);
      chk("d_aux", 64'(wb_aux), 64'h3);
      chk("d_busy", 64'(busy), 64'h1);
      tick();
    end
    wb_stall = 1'b0;
    #1 chk("d_unstall", 64'(p_stall), 64'h7);
    tick();
    #1 chk("d_burst1", 64'(wb_stb), 64'h1);
    tick();
    #1 chk("d_cap", 64'(wb_stb), 64'h0);
    p_stb[3] = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      wb_ack = 1'b1;
      #1 chk("d_ack", 64'(p_ack), 64'h8);
      tick();
    end
    wb_ack = 1'b0;
    p_cyc[3] = 1'b0;

    // Fill the 16-entry tag FIFO from port 0
    set_port(0, 1, 1, 0, 24'h40);
    tick();
    for (int g = 0; g < 8; g++) begin
      #1 chk("e_fill_a", 64'(wb_stb), 64'h1);
      tick();
      #1 chk("e_fill_b", 64'(wb_stb), 64'h1);
      tick();
      #1 chk("e_fill_gap", 64'(wb_stb), 64'h0);
      tick();
    end
    #1 chk("e_full_stb", 64'(wb_stb), 64'h0);
    chk("e_full_stall", 64'(p_stall), 64'hF);
    chk("e_full_cyc", 64'(wb_cyc), 64'h1);
    tick();
    wb_ack = 1'b1;
    #1 chk("e_full_pop_stb", 64'(wb_stb), 64'h0);
    chk("e_full_pop_ack", 64'(p_ack), 64'h1);
    tick();
    wb_ack = 1'b0;
    #1 chk("e_slot_stb", 64'(wb_stb), 64'h1);
    chk("e_slot_stall", 64'(p_stall), 64'hE);
    tick();
    #1 chk("e_refull", 64'(wb_stb), 64'h0);
    p_stb[0] = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      wb_ack = 1'b1;
      #1 chk("e_drain", 64'(p_ack), 64'h1);
      tick();
    end
    wb_ack = 1'b0;
    #1 chk("e_empty", 64'(busy), 64'h0);
    p_cyc[0] = 1'b0;

    // Port 1 abandons two outstanding reads; port 2's tag still routes
    set_port(1, 1, 1, 0, 24'h111);
    tick();
    #1 chk("f_aux1a", 64'(wb_aux), 64'h1);
    chk("f_stb1a", 64'(wb_stb), 64'h1);
    tick();
    #1 chk("f_stb1b", 64'(wb_stb), 64'h1);
    tick();
    set_port(1, 0, 0, 0, 24'h0);
    set_port(2, 1, 1, 0, 24'h222);
    #1 chk("f_gap", 64'(wb_stb), 64'h0);
    tick();
    #1 chk("f_aux2", 64'(wb_aux), 64'h2);
    chk("f_addr2", 64'(wb_addr), 64'h222);
    tick();
    p_stb[2] = 1'b0;
    tick();
    wb_ack = 1'b1;
    #1 chk("f_drop1", 64'(p_ack), 64'h0);
    tick();
    #1 chk("f_drop2", 64'(p_ack), 64'h0);
    tick();
    #1 chk("f_route2", 64'(p_ack), 64'h4);
    tick();
    wb_ack = 1'b0;
    #1 chk("f_busy", 64'(busy), 64'h0);
    chk("f_err", 64'(err_ack), 64'h0);
    p_cyc[2] = 1'b0;

    // Stray ack sets the sticky error; reset mid-burst clears everything
    do_reset("rst2");
    wb_ack = 1'b1;
    #1 chk("g_stray_ack", 64'(p_ack), 64'h0);
    tick();
    wb_ack = 1'b0;
    #1 chk("g_err", 64'(err_ack), 64'h1);
    tick();
    tick();
    #1 chk("g_err_hold", 64'(err_ack), 64'h1);
    set_port(0, 1, 1, 1, 24'h50);
    tick();
    #1 chk("g_mid_stb", 64'(wb_stb), 64'h1);
    tick();
    #1 chk("g_mid_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    #1 chk_reset("g_midrst");
    set_port(0, 0, 0, 0, 24'h0);
    tick();
    rst = 1'b0;
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    #1 chk("g_err_after_rst", 64'(err_ack), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
